// File: rtl/memory_copier.sv
// Word-by-word copy engine driving one memory's read/write handshake; watchdog on rdy.
// Optional running checksum of the words read: define MEMORY_COPIER_CHECKSUM_EN.
module memory_copier #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int TIMEOUT_SIZE = 8,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_SIZE-1:0] src_addr,
  input  logic [ADDRESS_SIZE-1:0] dst_addr,
  input  logic [ADDRESS_SIZE:0]   length,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    r_en,
  output logic [ADDRESS_SIZE-1:0] r_addr,
  input  logic [WORD_SIZE-1:0]    r_data,
  input  logic                    r_rdy,
  output logic                    w_en,
  output logic [ADDRESS_SIZE-1:0] w_addr,
  output logic [WORD_SIZE-1:0]    w_data,
  input  logic                    w_rdy,
`ifdef MEMORY_COPIER_CHECKSUM_EN
  output logic [WORD_SIZE-1:0]    checksum,
`endif
  output logic [1:0]              fsm_state
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [TIMEOUT_SIZE-1:0] TIMEOUT_V = TIMEOUT_SIZE'(TIMEOUT);

  state_t                  state, state_nx;
  logic [ADDRESS_SIZE-1:0] src, src_nx, dst, dst_nx;
  logic [ADDRESS_SIZE:0]   len, len_nx, count_nx, count_inc;
  logic [TIMEOUT_SIZE-1:0] wd, wd_nx, wd_inc;
  logic                    busy_nx, done_nx, error_nx, r_en_nx, w_en_nx;
  logic [ADDRESS_SIZE-1:0] r_addr_nx, w_addr_nx;
  logic [WORD_SIZE-1:0]    w_data_nx, csum, csum_nx;

  assign count_inc = count + 1'b1;
  assign wd_inc    = wd + 1'b1;
  assign fsm_state = state;
`ifdef MEMORY_COPIER_CHECKSUM_EN
  assign checksum  = csum;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      src    <= '0;
      dst    <= '0;
      len    <= '0;
      count  <= '0;
      wd     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      r_en   <= 1'b0;
      r_addr <= '0;
      w_en   <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
      csum   <= '0;
    end else begin
      state  <= state_nx;
      src    <= src_nx;
      dst    <= dst_nx;
      len    <= len_nx;
      count  <= count_nx;
      wd     <= wd_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      error  <= error_nx;
      r_en   <= r_en_nx;
      r_addr <= r_addr_nx;
      w_en   <= w_en_nx;
      w_addr <= w_addr_nx;
      w_data <= w_data_nx;
      csum   <= csum_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    src_nx    = src;
    dst_nx    = dst;
    len_nx    = len;
    count_nx  = count;
    wd_nx     = wd;
    done_nx   = 1'b0;
    error_nx  = error;
    r_en_nx   = r_en;
    r_addr_nx = r_addr;
    w_en_nx   = w_en;
    w_addr_nx = w_addr;
    w_data_nx = w_data;
    csum_nx   = csum;
    case (state)
      IDLE: begin
        if (start) begin
          src_nx   = src_addr;
          dst_nx   = dst_addr;
          len_nx   = length;
          count_nx = '0;
          error_nx = 1'b0;
          wd_nx    = '0;
          csum_nx  = '0;
          if (length == '0) begin
            state_nx = DONE;
          end else begin
            state_nx  = READ;
            r_en_nx   = 1'b1;
            r_addr_nx = src_addr;
          end
        end
      end
      READ: begin
        if (r_rdy) begin
          w_data_nx = r_data;
          csum_nx   = csum + r_data;
          r_en_nx   = 1'b0;
          w_en_nx   = 1'b1;
          w_addr_nx = dst + count[ADDRESS_SIZE-1:0];
          wd_nx     = '0;
          state_nx  = WRITE;
        end else if (wd_inc == TIMEOUT_V) begin
          error_nx = 1'b1;
          r_en_nx  = 1'b0;
          state_nx = DONE;
        end else begin
          wd_nx = wd_inc;
        end
      end
      WRITE: begin
        if (w_rdy) begin
          w_en_nx  = 1'b0;
          count_nx = count_inc;
          wd_nx    = '0;
          if (count_inc == len) begin
            state_nx = DONE;
          end else begin
            state_nx  = READ;
            r_en_nx   = 1'b1;
            r_addr_nx = src + count_inc[ADDRESS_SIZE-1:0];
          end
        end else if (wd_inc == TIMEOUT_V) begin
          error_nx = 1'b1;
          w_en_nx  = 1'b0;
          state_nx = DONE;
        end else begin
          wd_nx = wd_inc;
        end
      end
      DONE: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // busy is registered, so it follows the state being entered
    busy_nx = (state_nx == READ) || (state_nx == WRITE);
  end

endmodule

// File: tb/tb_memory_copier.sv
// Bench for memory_copier: behavioural memory responder plus an ascending-copy reference model.
// Handshake: a request is held until the edge where its rdy is high; rdy lasts one cycle.
module tb_memory_copier;
  localparam int W = 8;
  localparam int A = 4;
  localparam int DEPTH = 16;

  logic         clock = 1'b0;
  logic         reset, start;
  logic [A-1:0] src_addr, dst_addr;
  logic [A:0]   length;
  logic         busy, done, error, r_en, r_rdy, w_en, w_rdy;
  logic [A:0]   count;
  logic [A-1:0] r_addr, w_addr;
  logic [W-1:0] r_data, w_data;
  logic [1:0]   fsm_state;
`ifdef MEMORY_COPIER_CHECKSUM_EN
  logic [W-1:0] checksum;
`endif

  memory_copier dut (
    .clock(clock), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .error(error), .count(count),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data), .r_rdy(r_rdy),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_rdy(w_rdy),
`ifdef MEMORY_COPIER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] exp_mem [DEPTH];
  logic [W-1:0] exp_sum;
  logic [W-1:0] exp_q[$];
  logic [A-1:0] exp_ra_q[$];
  logic [A-1:0] exp_wa_q[$];
  bit fast = 1'b1;
  bit r_stall = 1'b0;
  bit overlap_seen, any_en_seen;
  int start_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // memory responder: rdy after 1..3 cycles of a held request (exactly 1 when fast)
  initial begin
    int rc, wc, rd, wdl;
    rc = 0; wc = 0; rd = 1; wdl = 1;
    r_rdy = 1'b0; w_rdy = 1'b0; r_data = '0;
    forever begin
      @(negedge clock);
      if (r_en && w_en) overlap_seen = 1'b1;
      if (r_en || w_en) any_en_seen = 1'b1;
      if (r_rdy) begin
        r_rdy = 1'b0; rc = 0;
      end else if (r_en && !r_stall) begin
        if (rc == 0) rd = fast ? 1 : int'($urandom_range(1, 3));
        rc++;
        if (rc >= rd) begin
          r_data = mem[r_addr];
          r_rdy = 1'b1;
          check("rd_expected", exp_ra_q.size() != 0, 1);
          if (exp_ra_q.size() != 0) check("rd_addr", r_addr, exp_ra_q.pop_front());
        end
      end else begin
        rc = 0;
      end
      if (w_rdy) begin
        w_rdy = 1'b0; wc = 0;
      end else if (w_en) begin
        if (wc == 0) wdl = fast ? 1 : int'($urandom_range(1, 3));
        wc++;
        if (wc >= wdl) begin
          mem[w_addr] = w_data;
          w_rdy = 1'b1;
          check("wr_expected", exp_wa_q.size() != 0, 1);
          if (exp_wa_q.size() != 0) begin
            check("wr_addr", w_addr, exp_wa_q.pop_front());
            check("wr_data", w_data, exp_q.pop_front());
          end
        end
      end else begin
        wc = 0;
      end
    end
  end

  // reference model: plain ascending copy over the current memory image
  task automatic prep(input logic [A-1:0] s, input logic [A-1:0] d, input logic [A:0] n);
    logic [A-1:0] ra, wa;
    exp_mem = mem;
    exp_sum = '0;
    exp_ra_q.delete(); exp_wa_q.delete(); exp_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      ra = s + A'(i);
      wa = d + A'(i);
      exp_ra_q.push_back(ra);
      exp_wa_q.push_back(wa);
      exp_q.push_back(exp_mem[ra]);
      exp_sum = exp_sum + exp_mem[ra];
      exp_mem[wa] = exp_mem[ra];
    end
  endtask

  task automatic launch(input logic [A-1:0] s, input logic [A-1:0] d, input logic [A:0] n);
    @(negedge clock);
    overlap_seen = 1'b0; any_en_seen = 1'b0;
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    start_cyc = cyc;
    check("error_clear_on_start", error, 0);
  endtask

  task automatic wait_done(input int budget, output int done_edge);
    done_edge = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (done) begin
        done_edge = cyc - start_cyc;
        break;
      end
    end
    check("done_seen", done_edge >= 0, 1);
  endtask

  task automatic finish_copy(input logic [A:0] n, input bit timed, input int done_edge);
    int bad;
    bad = 0;
    check("count_at_done", count, n);
    check("error_at_done", error, 0);
    check("no_overlap_en", overlap_seen, 0);
    check("queues_drained", exp_ra_q.size() + exp_wa_q.size(), 0);
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== exp_mem[a]) bad++;
    check("mem_contents", bad, 0);
    if (n == 0) check("zero_len_no_access", any_en_seen, 0);
    if (timed) check("done_edge", done_edge, 2 * int'(n) + 1);
`ifdef MEMORY_COPIER_CHECKSUM_EN
    check("checksum", checksum, exp_sum);
`endif
    @(negedge clock);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic run_copy(input logic [A-1:0] s, input logic [A-1:0] d, input logic [A:0] n,
                          input bit timed);
    int de;
    fast = timed;
    prep(s, d, n);
    launch(s, d, n);
    wait_done(1000, de);
    finish_copy(n, timed, de);
  endtask

  // global time limit
  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] snap [DEPTH];
    int de, found, pulses;
    reset = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    for (int a = 0; a < DEPTH; a++) mem[a] = W'($urandom);
    #2 reset = 1'b1;
    #1;
    check("reset_outputs", {busy, done, error, count, r_en, r_addr, w_en, w_addr, w_data}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // basic copy
    for (int a = 0; a < 4; a++) mem[a] = W'(8'h10 + a);
    run_copy(4'd0, 4'd8, 5'd4, 1'b1);
    for (int a = 0; a < 4; a++) check("basic_readback", mem[8 + a], 8'h10 + a);

    // zero length
    run_copy(4'd5, 4'd9, 5'd0, 1'b1);

    // wrap-around and overlapping ranges
    run_copy(4'd14, 4'd6, 5'd4, 1'b1);
    run_copy(4'd2, 4'd4, 5'd6, 1'b0);
    run_copy(4'd9, 4'd3, 5'd16, 1'b1);

    // randomized copies with random rdy latency
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < DEPTH; a++) mem[a] = W'($urandom);
      run_copy(A'($urandom), A'($urandom), (A + 1)'($urandom_range(1, 16)), 1'b0);
    end

    // timeout: read never answered
    fast = 1'b1; r_stall = 1'b1;
    snap = mem;
    exp_ra_q.delete(); exp_wa_q.delete(); exp_q.delete();
    launch(4'd3, 4'd5, 5'd3);
    wait_done(400, de);
    check("timeout_error", error, 1);
    check("timeout_count", count, 0);
    check("timeout_r_en_dropped", r_en, 0);
    check("timeout_latency", (de >= 254 && de <= 258), 1);
    found = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== snap[a]) found++;
    check("timeout_mem_untouched", found, 0);
    r_stall = 1'b0;
    repeat (3) @(negedge clock);
    check("error_sticky", error, 1);
    run_copy(4'd1, 4'd12, 5'd3, 1'b1);

    // start while busy is ignored, then reset mid-copy
    fast = 1'b1;
    prep(4'd0, 4'd10, 5'd5);
    launch(4'd0, 4'd10, 5'd5);
    found = 0;
    for (int k = 0; k < 50 && found == 0; k++) begin
      @(negedge clock);
      if (w_en && count == 1) found = 1;
    end
    check("reached_word2_write", found, 1);
    src_addr = 4'd7; dst_addr = 4'd1; length = 5'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("ignored_start_raddr", r_addr, 2);
    check("ignored_start_count", count, 2);
    check("ignored_start_busy", busy, 1);
    found = 0;
    for (int k = 0; k < 50 && found == 0; k++) begin
      @(negedge clock);
      if (w_en) found = 1;
    end
    check("reached_word3_write", found, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", {busy, done, error, count, r_en, r_addr, w_en, w_addr, w_data}, 0);
    pulses = 0;
    repeat (2) begin
      @(negedge clock);
      if (done) pulses++;
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (done) pulses++;
    end
    check("no_done_after_reset", pulses, 0);
    run_copy(4'd12, 4'd3, 5'd2, 1'b1);

`ifdef MEMORY_COPIER_CHECKSUM_EN
    mem[0] = 8'hFF; mem[1] = 8'h02; mem[2] = 8'h10;
    run_copy(4'd0, 4'd4, 5'd3, 1'b1);
    check("checksum_directed", checksum, 8'h11);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_copier.md
Name: memory_copier

Overview:
- Initiator for the `memory` block's read/write handshake interface. It drives `r_en`/`r_addr` and `w_en`/`w_addr`/`w_data`, and consumes `r_data`/`r_rdy`/`w_rdy`.
- On a start command it copies `length` words from a source range to a destination range.
- Completion is reported with a done pulse. A watchdog flags a memory that never answers.
- Sits between the control logic and one `memory` instance.

Parameters:
- WORD_SIZE, 8, data word width; must match the memory.
- ADDRESS_SIZE, 4, address width; must match the memory.
- TIMEOUT_SIZE, 8, width of the watchdog counter.
- TIMEOUT, 255, cycles a request may wait for rdy before error; must fit in TIMEOUT_SIZE bits.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  copy request, sampled only in IDLE.
- src_addr  in  ADDRESS_SIZE  first source address.
- dst_addr  in  ADDRESS_SIZE  first destination address.
- length  in  ADDRESS_SIZE+1  word count, 0..2^ADDRESS_SIZE.
- busy  out  1  high in READ and WRITE.
- done  out  1  one-cycle completion pulse.
- error  out  1  watchdog fired; sticky until the next accepted start.
- count  out  ADDRESS_SIZE+1  words written in the current or last copy.
- r_en  out  1  read request.
- r_addr  out  ADDRESS_SIZE  read address.
- r_data  in  WORD_SIZE  read data, valid while r_rdy is high.
- r_rdy  in  1  read complete.
- w_en  out  1  write request.
- w_addr  out  ADDRESS_SIZE  write address.
- w_data  out  WORD_SIZE  write data.
- w_rdy  in  1  write complete.

Behaviour:
- Reset (asynchronous, active-high): every output goes to 0 immediately and the FSM goes to IDLE. A reset during a copy abandons it; no done pulse is produced.
- All outputs are registered.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On an edge with start=1, latch src, dst and len; clear count, error and the watchdog.
  - len=0: go to DONE; no memory access.
  - Otherwise: go to READ with r_en=1 and r_addr=src.
- READ:
  - Hold r_en and r_addr stable until an edge with r_rdy=1.
  - On that edge: w_data<=r_data, r_en<=0, w_en<=1, w_addr<=dst+count; go to WRITE.
- WRITE:
  - Hold w_en, w_addr and w_data stable until an edge with w_rdy=1.
  - On that edge: w_en<=0, count<=count+1.
  - If count+1==len: go to DONE.
  - Else: go to READ with r_en<=1 and r_addr<=src+count+1 on the same edge.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0.
- Request exclusivity: r_en and w_en are never high in the same cycle.
- Ignored rdy: an rdy seen while its own enable is low is ignored.
- Address arithmetic: modulo 2^ADDRESS_SIZE; both ranges wrap past the top address.
- Copy order and overlap: the copy is always ascending. With overlapping ranges and dst>src, destination words overwrite source words before they are read. This is defined behaviour; there is no protection.
- Start handling: start while busy or in DONE is ignored. The input ports are not re-sampled mid-copy.
- Throughput: with rdy returned on the first cycle of each request, each word takes 2 cycles. done rises on edge 2N+1 counting the start-sampling edge as edge 0 (len=0: edge 1).
- Watchdog:
  - Cleared on every entry to READ or WRITE; increments each cycle rdy is low.
  - On reaching TIMEOUT: error<=1, drop both enables, go to DONE. done still pulses.
  - count holds the number of words fully written.

Optional Feature:
- Macro: MEMORY_COPIER_CHECKSUM_EN.
- When defined:
  - Adds output port `checksum`, WORD_SIZE bits, cleared on an accepted start.
  - Each accepted read word is added modulo 2^WORD_SIZE on the r_rdy edge.
  - Final value is valid when done pulses.
- When undefined: the port and the adder are absent, and behaviour is otherwise identical.

Test Plan:
- Basic copy:
  - Stimulus: memory preloaded 0x10..0x13 at addresses 0-3; start src=0, dst=8, len=4; READ/WRITE_DELAY=1.
  - Required: addresses 8-11 read back 0x10..0x13; count=4; one done pulse; error=0; r_en and w_en never high together.
- Zero length:
  - Stimulus: len=0.
  - Required: done on edge 1; r_en and w_en never asserted; count=0.
- Wrap-around:
  - Stimulus: src=14, dst=6, len=4.
  - Required: reads at 14, 15, 0, 1; writes at 6-9 with matching data.
- Timeout:
  - Stimulus: r_rdy tied low, TIMEOUT=255.
  - Required: error=1 and done pulse about 256 cycles after r_en rises; r_en drops; count=0; the next start clears error.
- Reset mid-copy and start while busy:
  - Stimulus: pulse start during WRITE of word 2, then assert reset.
  - Required: the extra start has no effect; on reset, outputs go to 0 without waiting for a clock edge and there is no done pulse.
  - Required: a following start with len=2 completes normally.
- Checksum (MEMORY_COPIER_CHECKSUM_EN defined):
  - Stimulus: copy words 0xFF, 0x02, 0x10.
  - Required: checksum=0x11 at done.
